// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, ring-state encoding and control-word layout.
package sap1_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    // One-hot ring: bit index n is state T(n+1).
    localparam int T_W    = 6;
    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

    localparam logic [T_W-1:0] ST_T1   = 6'b000001;
    localparam logic [T_W-1:0] ST_T2   = 6'b000010;
    localparam logic [T_W-1:0] ST_T3   = 6'b000100;
    localparam logic [T_W-1:0] ST_T4   = 6'b001000;
    localparam logic [T_W-1:0] ST_T5   = 6'b010000;
    localparam logic [T_W-1:0] ST_T6   = 6'b100000;
    localparam logic [T_W-1:0] ST_HALT = 6'b000000;

    // Control-word bit positions.
    localparam int CW_W            = 12;
    localparam int CW_PC_INC       = 11;
    localparam int CW_PC_ENABLE    = 10;
    localparam int CW_MAR_LOAD_N   = 9;
    localparam int CW_RAM_ENABLE_N = 8;
    localparam int CW_IR_LOAD_N    = 7;
    localparam int CW_IR_ENABLE_N  = 6;
    localparam int CW_A_LOAD_N     = 5;
    localparam int CW_A_ENABLE     = 4;
    localparam int CW_ALU_SUB      = 3;
    localparam int CW_ALU_ENABLE   = 2;
    localparam int CW_B_LOAD_N     = 1;
    localparam int CW_OUT_LOAD_N   = 0;

    // Every signal at its inactive level: active-low bits high, active-high bits low.
    localparam logic [CW_W-1:0] CW_IDLE =
        (12'd1 << CW_MAR_LOAD_N)   | (12'd1 << CW_RAM_ENABLE_N) |
        (12'd1 << CW_IR_LOAD_N)    | (12'd1 << CW_IR_ENABLE_N)  |
        (12'd1 << CW_A_LOAD_N)     | (12'd1 << CW_B_LOAD_N)     |
        (12'd1 << CW_OUT_LOAD_N);

    // Drive one control bit to its active level, whatever its polarity.
    function automatic logic [CW_W-1:0] cw_assert(input logic [CW_W-1:0] cw, input int idx);
        logic [CW_W-1:0] r;
        r      = cw;
        r[idx] = ~CW_IDLE[idx];
        return r;
    endfunction

endpackage

// File: rtl/sap1_controller_sequencer_ring_counter.sv
// Six-bit one-hot ring counter with advance enable and synchronous active-low reset.
module ring_counter
    import sap1_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           advance,
    output logic [T_W-1:0] state
);

    logic [T_W-1:0] state_q;
    logic [T_W-1:0] state_d;

    // Rotate one position toward T6 on advance, wrapping T6 back to T1.
    always_comb begin
        state_d = advance ? {state_q[T_W-2:0], state_q[T_W-1]} : state_q;
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_T1;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: ring timing, opcode decode, halt latch and single-step.
module sap1_controller_sequencer
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                manual,
    input  logic                step,
    output logic [T_W-1:0]      t_state,
    output logic                halted,
    output logic                pc_inc,
    output logic                pc_enable,
    output logic                mar_load_n,
    output logic                ram_enable_n,
    output logic                ir_load_n,
    output logic                ir_enable_n,
    output logic                a_load_n,
    output logic                a_enable,
    output logic                alu_sub,
    output logic                alu_enable,
    output logic                b_load_n,
    output logic                out_load_n
);

    logic           step_q, step_d;
    logic           halted_q, halted_d;
    logic           step_rise;
    logic           advance;
    logic [T_W-1:0] ring_state;
    logic [CW_W-1:0] cw;

    ring_counter u_ring (
        .clk     (clk),
        .rst_n   (reset),
        .advance (advance),
        .state   (ring_state)
    );

    // Advance every cycle in free-run; in manual only on a fresh step edge. Never in HALT.
    always_comb begin
        step_rise = step & ~step_q;
        advance   = ~halted_q & (~manual | step_rise);
        step_d    = step;
        halted_d  = halted_q | (advance & ring_state[T4_IDX] & (opcode == OP_HLT));
    end

    // Step history and halt latch; reset clears both and wins over a same-edge halt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Control-word decode from ring state and opcode; opcode matters only in T4..T6.
    always_comb begin
        // NOTE: cw gets a full default first so no path through the case can infer a latch.
        cw = CW_IDLE;
        if (reset && !halted_q) begin
            case (ring_state)
                ST_T1: begin
                    cw = cw_assert(cw, CW_PC_ENABLE);
                    cw = cw_assert(cw, CW_MAR_LOAD_N);
                end
                ST_T2: cw = cw_assert(cw, CW_PC_INC);
                ST_T3: begin
                    cw = cw_assert(cw, CW_RAM_ENABLE_N);
                    cw = cw_assert(cw, CW_IR_LOAD_N);
                end
                ST_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw = cw_assert(cw, CW_IR_ENABLE_N);
                            cw = cw_assert(cw, CW_MAR_LOAD_N);
                        end
                        OP_OUT: begin
                            cw = cw_assert(cw, CW_A_ENABLE);
                            cw = cw_assert(cw, CW_OUT_LOAD_N);
                        end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (opcode)
                        OP_LDA: begin
                            cw = cw_assert(cw, CW_RAM_ENABLE_N);
                            cw = cw_assert(cw, CW_A_LOAD_N);
                        end
                        OP_ADD, OP_SUB: begin
                            cw = cw_assert(cw, CW_RAM_ENABLE_N);
                            cw = cw_assert(cw, CW_B_LOAD_N);
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cw = cw_assert(cw, CW_ALU_ENABLE);
                        cw = cw_assert(cw, CW_A_LOAD_N);
                        if (opcode == OP_SUB) cw = cw_assert(cw, CW_ALU_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state      = (reset && !halted_q) ? ring_state : ST_HALT;
    assign halted       = reset & halted_q;
    assign pc_inc       = cw[CW_PC_INC];
    assign pc_enable    = cw[CW_PC_ENABLE];
    assign mar_load_n   = cw[CW_MAR_LOAD_N];
    assign ram_enable_n = cw[CW_RAM_ENABLE_N];
    assign ir_load_n    = cw[CW_IR_LOAD_N];
    assign ir_enable_n  = cw[CW_IR_ENABLE_N];
    assign a_load_n     = cw[CW_A_LOAD_N];
    assign a_enable     = cw[CW_A_ENABLE];
    assign alu_sub      = cw[CW_ALU_SUB];
    assign alu_enable   = cw[CW_ALU_ENABLE];
    assign b_load_n     = cw[CW_B_LOAD_N];
    assign out_load_n   = cw[CW_OUT_LOAD_N];

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Self-checking bench for the SAP-1 controller-sequencer.
module tb_sap1_controller_sequencer;

    logic       clk = 1'b0;
    logic       reset, manual, step;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       halted;
    logic       pc_inc, pc_enable, mar_load_n, ram_enable_n, ir_load_n, ir_enable_n;
    logic       a_load_n, a_enable, alu_sub, alu_enable, b_load_n, out_load_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: phase 1..6 within the instruction, halt flag, step history.
    int phase  = 1;
    bit m_halt = 1'b0;
    bit m_hist = 1'b0;

    // Control words in port order pc_inc .. out_load_n, raw pin polarity.
    localparam logic [11:0] W_IDLE  = 12'h3E3;
    localparam logic [11:0] W_F1    = 12'h5E3;
    localparam logic [11:0] W_F2    = 12'hBE3;
    localparam logic [11:0] W_F3    = 12'h263;
    localparam logic [11:0] W_ADDR  = 12'h1A3;
    localparam logic [11:0] W_LDA5  = 12'h2C3;
    localparam logic [11:0] W_ALU5  = 12'h2E1;
    localparam logic [11:0] W_ADD6  = 12'h3C7;
    localparam logic [11:0] W_SUB6  = 12'h3CF;
    localparam logic [11:0] W_OUT4  = 12'h3F2;

    typedef struct {
        logic       r, m, s;
        logic [3:0] op;
        logic [5:0] t;
        logic       h;
        logic [11:0] cw;
    } vec_t;

    vec_t tbl[$];

    sap1_controller_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .manual(manual), .step(step),
        .t_state(t_state), .halted(halted),
        .pc_inc(pc_inc), .pc_enable(pc_enable), .mar_load_n(mar_load_n),
        .ram_enable_n(ram_enable_n), .ir_load_n(ir_load_n), .ir_enable_n(ir_enable_n),
        .a_load_n(a_load_n), .a_enable(a_enable), .alu_sub(alu_sub),
        .alu_enable(alu_enable), .b_load_n(b_load_n), .out_load_n(out_load_n)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] dut_vec();
        return {t_state, halted, pc_inc, pc_enable, mar_load_n, ram_enable_n, ir_load_n,
                ir_enable_n, a_load_n, a_enable, alu_sub, alu_enable, b_load_n, out_load_n};
    endfunction

    // Execute-phase words by instruction: fetch is shared, T4..T6 depend on opcode.
    function automatic logic [11:0] model_cw(input int ph, input logic [3:0] op);
        logic [11:0] ex[3];
        if (ph == 1) return W_F1;
        if (ph == 2) return W_F2;
        if (ph == 3) return W_F3;
        case (op)
            4'h0:    ex = '{W_ADDR, W_LDA5, W_IDLE};
            4'h1:    ex = '{W_ADDR, W_ALU5, W_ADD6};
            4'h2:    ex = '{W_ADDR, W_ALU5, W_SUB6};
            4'hE:    ex = '{W_OUT4, W_IDLE, W_IDLE};
            default: ex = '{W_IDLE, W_IDLE, W_IDLE};
        endcase
        return ex[ph-4];
    endfunction

    function automatic logic [18:0] model_vec(input logic r, input logic [3:0] op);
        logic [5:0] t;
        if (!r)     return {6'd0, 1'b0, W_IDLE};
        if (m_halt) return {6'd0, 1'b1, W_IDLE};
        t = 6'd1 << (phase - 1);
        return {t, 1'b0, model_cw(phase, op)};
    endfunction

    task automatic model_step(input logic r, m, s, input logic [3:0] op);
        bit adv;
        if (!r) begin
            phase = 1; m_halt = 1'b0; m_hist = 1'b0;
        end else begin
            adv = !m_halt && (!m || (s && !m_hist));
            if (adv) begin
                if (phase == 4 && op == 4'hF) m_halt = 1'b1;
                phase = (phase == 6) ? 1 : phase + 1;
            end
            m_hist = s;
        end
    endtask

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, compare against the model (and an optional
    // fixed expectation), cross one posedge, and return at the following negedge.
    task automatic apply(input logic r, m, s, input logic [3:0] op, input string name,
                         input bit has_exp, input logic [18:0] exp);
        reset = r; manual = m; step = s; opcode = op;
        #1;
        check({name, "/model"}, dut_vec(), model_vec(r, op));
        if (has_exp) check(name, dut_vec(), exp);
        @(posedge clk);
        model_step(r, m, s, op);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, m, s, input logic [3:0] op,
                                input logic [5:0] t, input logic h, input logic [11:0] cw);
        vec_t v;
        v.r = r; v.m = m; v.s = s; v.op = op; v.t = t; v.h = h; v.cw = cw;
        return v;
    endfunction

    initial begin
        reset = 1'b0; manual = 1'b0; step = 1'b0; opcode = 4'h0;

        // Reset, then free-run ADD, SUB, OUT, undefined 7, HLT.
        repeat (3) tbl.push_back(mk(0, 0, 0, 4'h0, 6'h00, 0, W_IDLE));
        tbl.push_back(mk(1, 0, 0, 4'h0, 6'h01, 0, W_F1));
        tbl.push_back(mk(1, 0, 0, 4'h1, 6'h02, 0, W_F2));
        tbl.push_back(mk(1, 0, 0, 4'h1, 6'h04, 0, W_F3));
        tbl.push_back(mk(1, 0, 0, 4'h1, 6'h08, 0, W_ADDR));
        tbl.push_back(mk(1, 0, 0, 4'h1, 6'h10, 0, W_ALU5));
        tbl.push_back(mk(1, 0, 0, 4'h1, 6'h20, 0, W_ADD6));
        tbl.push_back(mk(1, 0, 0, 4'h2, 6'h01, 0, W_F1));
        tbl.push_back(mk(1, 0, 0, 4'h2, 6'h02, 0, W_F2));
        tbl.push_back(mk(1, 0, 0, 4'h2, 6'h04, 0, W_F3));
        tbl.push_back(mk(1, 0, 0, 4'h2, 6'h08, 0, W_ADDR));
        tbl.push_back(mk(1, 0, 0, 4'h2, 6'h10, 0, W_ALU5));
        tbl.push_back(mk(1, 0, 0, 4'h2, 6'h20, 0, W_SUB6));
        tbl.push_back(mk(1, 0, 0, 4'hE, 6'h01, 0, W_F1));
        tbl.push_back(mk(1, 0, 0, 4'hE, 6'h02, 0, W_F2));
        tbl.push_back(mk(1, 0, 0, 4'hE, 6'h04, 0, W_F3));
        tbl.push_back(mk(1, 0, 0, 4'hE, 6'h08, 0, W_OUT4));
        tbl.push_back(mk(1, 0, 0, 4'hE, 6'h10, 0, W_IDLE));
        tbl.push_back(mk(1, 0, 0, 4'hE, 6'h20, 0, W_IDLE));
        tbl.push_back(mk(1, 0, 0, 4'h7, 6'h01, 0, W_F1));
        tbl.push_back(mk(1, 0, 0, 4'h7, 6'h02, 0, W_F2));
        tbl.push_back(mk(1, 0, 0, 4'h7, 6'h04, 0, W_F3));
        tbl.push_back(mk(1, 0, 0, 4'h7, 6'h08, 0, W_IDLE));
        tbl.push_back(mk(1, 0, 0, 4'h7, 6'h10, 0, W_IDLE));
        tbl.push_back(mk(1, 0, 0, 4'h7, 6'h20, 0, W_IDLE));
        tbl.push_back(mk(1, 0, 0, 4'hF, 6'h01, 0, W_F1));
        tbl.push_back(mk(1, 0, 0, 4'hF, 6'h02, 0, W_F2));
        tbl.push_back(mk(1, 0, 0, 4'hF, 6'h04, 0, W_F3));
        tbl.push_back(mk(1, 0, 0, 4'hF, 6'h08, 0, W_IDLE));
        tbl.push_back(mk(1, 0, 0, 4'hF, 6'h00, 1, W_IDLE));

        @(negedge clk);
        foreach (tbl[i])
            apply(tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].op, $sformatf("vec%0d", i), 1'b1,
                  {tbl[i].t, tbl[i].h, tbl[i].cw});

        // HALT holds for 22 cycles whatever manual/step/opcode do.
        for (int i = 0; i < 22; i++)
            apply(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                  "halt_hold", 1'b1, {6'h00, 1'b1, W_IDLE});

        // Reset returns to T1.
        apply(0, 0, 0, 4'h0, "halt_reset", 1'b1, {6'h00, 1'b0, W_IDLE});
        apply(1, 1, 0, 4'h0, "man_t1", 1'b1, {6'h01, 1'b0, W_F1});

        // Manual: one edge to T2, hold low 10 cycles, 1-cycle pulse, then 5-cycle high.
        apply(1, 1, 1, 4'h0, "man_edge1", 1'b1, {6'h01, 1'b0, W_F1});
        for (int i = 0; i < 10; i++)
            apply(1, 1, 0, 4'h0, "man_hold_t2", 1'b1, {6'h02, 1'b0, W_F2});
        apply(1, 1, 1, 4'h0, "man_pulse", 1'b1, {6'h02, 1'b0, W_F2});
        apply(1, 1, 0, 4'h0, "man_t3", 1'b1, {6'h04, 1'b0, W_F3});
        apply(1, 1, 1, 4'h0, "man_high0", 1'b1, {6'h04, 1'b0, W_F3});
        for (int i = 0; i < 4; i++)
            apply(1, 1, 1, 4'h0, "man_high", 1'b1, {6'h08, 1'b0, W_ADDR});
        apply(1, 1, 0, 4'h0, "man_t4", 1'b1, {6'h08, 1'b0, W_ADDR});

        // Switch to free-run at T4 with HLT, then a manual step edge in HALT is ignored.
        apply(1, 0, 0, 4'hF, "hlt_t4", 1'b1, {6'h08, 1'b0, W_IDLE});
        apply(1, 1, 0, 4'hF, "halt_m0", 1'b1, {6'h00, 1'b1, W_IDLE});
        apply(1, 1, 1, 4'hF, "halt_m1", 1'b1, {6'h00, 1'b1, W_IDLE});
        apply(1, 1, 0, 4'hF, "halt_m2", 1'b1, {6'h00, 1'b1, W_IDLE});
        apply(1, 0, 0, 4'h0, "halt_fr", 1'b1, {6'h00, 1'b1, W_IDLE});

        // Reset asserted in T5 of LDA aborts it with a_load_n held high.
        apply(0, 0, 0, 4'h0, "lda_rst", 1'b0, '0);
        apply(1, 0, 0, 4'h0, "lda_t1", 1'b1, {6'h01, 1'b0, W_F1});
        apply(1, 0, 0, 4'h0, "lda_t2", 1'b0, '0);
        apply(1, 0, 0, 4'h0, "lda_t3", 1'b0, '0);
        apply(1, 0, 0, 4'h0, "lda_t4", 1'b1, {6'h08, 1'b0, W_ADDR});
        apply(0, 0, 0, 4'h0, "lda_t5_rst", 1'b1, {6'h00, 1'b0, W_IDLE});
        apply(0, 0, 0, 4'h0, "lda_rst_hold", 1'b1, {6'h00, 1'b0, W_IDLE});
        apply(1, 0, 0, 4'h0, "lda_restart", 1'b1, {6'h01, 1'b0, W_F1});

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 5))
                0: op = 4'h0;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'hE;
                4: op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
                default: op = 4'($urandom);
            endcase
            apply(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), op, "rand", 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
